axis_frame_loader: RTL
======================

Name: axis_frame_loader

Overview:
- AXI-Stream slave that takes frames from the DMA MM2S channel on the PS side.
- Unpacks each 32-bit beat into one DATA_SIZE sample and drives the frame-RAM write port (FramData/FramAdd/FramEn) at addresses 0..LENGTH-1.
- It is the inbound counterpart of the outbound S2MM frame path: software reloads a capture frame into the frame RAM for replay or analysis.
- It checks frame length and tkeep, and reports status to the APB register block.

Parameters:
- DATA_SIZE, 12, sample width; taken from tdata[DATA_SIZE-1:0].
- LENGTH, 32768, samples per frame; tlast expected on beat LENGTH-1.
- LENGTH_SIZE, 15, address width, clog2(LENGTH).

Ports:
- clk  in  1  single clock, the clk350 domain.
- rstn  in  1  synchronous active-low reset.
- Start  in  1  one-cycle pulse from the register block; arms a frame load.
- Hold  in  1  backpressure request; while high, tready is held low.
- s_axis_tdata  in  32  stream data; only bits [DATA_SIZE-1:0] are used.
- s_axis_tkeep  in  4  byte enables; must be 4'hF.
- s_axis_tlast  in  1  end of frame.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accept.
- FramData  out  DATA_SIZE  RAM write data.
- FramAdd  out  LENGTH_SIZE  RAM write address.
- FramEn  out  1  RAM write enable.
- Busy  out  1  high in LOAD or DRAIN.
- Done  out  1  one-cycle pulse at end of frame.
- ErrShort  out  1  sticky: tlast arrived before beat LENGTH-1.
- ErrLong  out  1  sticky: no tlast on beat LENGTH-1.
- ErrKeep  out  1  sticky: an accepted beat had tkeep != 4'hF.
- BeatCount  out  LENGTH_SIZE+1  number of beats accepted in the current or last frame, including drained beats, saturating at all-ones.

Behaviour:
- Reset (rstn low at a clk edge):
  - State goes to IDLE; address counter and BeatCount go to 0.
  - FramData, FramAdd, FramEn, Done, Busy and all error flags go to 0.
  - Mid-frame reset abandons the frame; nothing more is written.
- Beat acceptance: a beat is accepted when tvalid and tready are both high.
  - tready = (state==LOAD or state==DRAIN) and !Hold. It is combinational from the registered state and Hold, so it never depends on tvalid.
- IDLE:
  - Start=1 clears ErrShort, ErrLong, ErrKeep and BeatCount, sets the address counter to 0, and moves to LOAD.
  - Start in any other state is ignored.
- LOAD, on each accepted beat:
  - Next cycle: FramData = tdata[DATA_SIZE-1:0], FramAdd = counter, FramEn = 1. Write latency is 1 cycle; FramEn is 0 in every cycle after a non-accepted one.
  - Counter increments; BeatCount increments.
  - tlast=1 with counter==LENGTH-1: go to DONE (normal end of frame).
  - tlast=1 with counter<LENGTH-1: beat is written, ErrShort set, go to DONE.
  - tlast=0 with counter==LENGTH-1: beat is written, ErrLong set, go to DRAIN. The counter does not wrap into address 0.
- DRAIN:
  - Accepted beats are discarded (FramEn stays 0) and counted in BeatCount.
  - Accepted tlast goes to DONE.
- DONE:
  - Done=1 for exactly one cycle, tready=0, then go to IDLE.
  - Start arriving in the DONE cycle is ignored.
- ErrKeep:
  - Set on any accepted beat with tkeep != 4'hF, in LOAD or DRAIN.
  - The data is still written (in LOAD).
- tdata bits above DATA_SIZE are ignored.
- Busy = (state==LOAD or state==DRAIN), registered alongside the state.
- Hold:
  - Can toggle on any cycle; stalls acceptance only.
  - A tvalid beat held through Hold is accepted exactly once when Hold falls.

Test Plan (bench overrides LENGTH=8, LENGTH_SIZE=3):
- Normal frame: Start, then 8 beats tdata=0x100+i, tkeep=F, tlast on beat 7, tvalid continuous.
  -> FramEn on 8 consecutive cycles, FramAdd 0..7, FramData 0x100..0x107, one Done pulse, BeatCount=8, no error flags.
- Short frame: Start, then 5 beats with tlast on beat 4.
  -> writes at addresses 0..4, ErrShort=1, Done pulse, BeatCount=5, state back to IDLE.
- Long frame: Start, then 11 beats with tlast on beat 10.
  -> writes at addresses 0..7 only, ErrLong=1, beats 8..10 accepted with no FramEn, Done after beat 10, BeatCount=11.
- Backpressure: normal frame with Hold high for 3 cycles around beat 3 and tvalid gaps at random.
  -> tready low during Hold, each beat written exactly once, addresses 0..7 in order, Done pulse.
- Keep error and restart: beat 2 with tkeep=4'h3, then a second Start.
  -> ErrKeep=1 after frame 1 and address 2 still written; the second Start clears ErrKeep and BeatCount to 0.
- Reset mid-frame: rstn low for 1 cycle after beat 4, then Start and a full frame.
  -> all outputs 0 the cycle after reset, no Done for the aborted frame, the new frame writes from address 0, Start during Busy is ignored.

Source files
------------

// File: rtl/axis_frame_loader.sv
// rtl/axis_frame_loader.sv - AXI-Stream slave that loads one frame of samples into the frame RAM
//
// Purpose:
//   Accepts a frame from the DMA MM2S stream, unpacks each 32-bit beat into one
//   DATA_SIZE sample and writes it to the frame RAM at addresses 0..LENGTH-1.
//   Frame length and tkeep are checked; sticky status is reported upward.
//
// Ports:
//   clk, rstn          single clock, synchronous active-low reset
//   Start              one-cycle pulse, arms a frame load (only honoured in IDLE)
//   Hold               backpressure request, forces s_axis_tready low
//   s_axis_*           AXI-Stream slave (tdata/tkeep/tlast/tvalid in, tready out)
//   FramData/FramAdd/FramEn  frame-RAM write port, one cycle after acceptance
//   Busy               high while loading or draining
//   Done               one-cycle pulse at end of frame
//   ErrShort/ErrLong/ErrKeep sticky frame errors, cleared by the next Start
//   BeatCount          accepted beats in current/last frame, saturating

module axis_frame_loader #(
  parameter int DATA_SIZE   = 12,
  parameter int LENGTH      = 32768,
  parameter int LENGTH_SIZE = 15
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   Start,
  input  logic                   Hold,
  input  logic [31:0]            s_axis_tdata,
  input  logic [3:0]             s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [DATA_SIZE-1:0]   FramData,
  output logic [LENGTH_SIZE-1:0] FramAdd,
  output logic                   FramEn,
  output logic                   Busy,
  output logic                   Done,
  output logic                   ErrShort,
  output logic                   ErrLong,
  output logic                   ErrKeep,
  output logic [LENGTH_SIZE:0]   BeatCount
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [LENGTH_SIZE-1:0] LAST_ADDR = LENGTH_SIZE'(LENGTH - 1);

  state_t                 state_q, state_d;
  logic [LENGTH_SIZE-1:0] addr_q, addr_d;
  logic [LENGTH_SIZE:0]   beat_count_q, beat_count_d;
  logic [DATA_SIZE-1:0]   fram_data_q, fram_data_d;
  logic [LENGTH_SIZE-1:0] fram_add_q, fram_add_d;
  logic                   fram_en_q, fram_en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_short_q, err_short_d;
  logic                   err_long_q, err_long_d;
  logic                   err_keep_q, err_keep_d;

  logic                   accept;
  logic                   keep_bad;
  logic                   at_last_addr;
  logic [LENGTH_SIZE:0]   beat_count_inc;

  // Only the low DATA_SIZE bits of each beat carry a sample.
  logic unused_tdata_hi;
  assign unused_tdata_hi = ^s_axis_tdata[31:DATA_SIZE];

  // tready depends only on registered state and Hold, never on tvalid.
  assign s_axis_tready = ((state_q == S_LOAD) || (state_q == S_DRAIN)) && !Hold;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign keep_bad      = (s_axis_tkeep != 4'hF);
  assign at_last_addr  = (addr_q == LAST_ADDR);

  // Beat counter sticks at all-ones so a runaway frame cannot wrap it to a small value.
  assign beat_count_inc = (beat_count_q == '1) ? beat_count_q
                                               : beat_count_q + (LENGTH_SIZE+1)'(1);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beat_count_d = beat_count_q;
    fram_data_d  = fram_data_q;
    fram_add_d   = fram_add_q;
    fram_en_d    = 1'b0;
    err_short_d  = err_short_q;
    err_long_d   = err_long_q;
    err_keep_d   = err_keep_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          err_short_d  = 1'b0;
          err_long_d   = 1'b0;
          err_keep_d   = 1'b0;
          beat_count_d = '0;
          addr_d       = '0;
          state_d      = S_LOAD;
        end
      end

      S_LOAD: begin
        if (accept) begin
          fram_data_d  = s_axis_tdata[DATA_SIZE-1:0];
          fram_add_d   = addr_q;
          fram_en_d    = 1'b1;
          beat_count_d = beat_count_inc;
          if (keep_bad) begin
            err_keep_d = 1'b1;
          end
          // The address counter parks on the last address rather than
          // wrapping, so an overlong frame can never overwrite address 0.
          if (!at_last_addr) begin
            addr_d = addr_q + LENGTH_SIZE'(1);
          end
          if (s_axis_tlast) begin
            if (!at_last_addr) begin
              err_short_d = 1'b1;
            end
            state_d = S_DONE;
          end else if (at_last_addr) begin
            err_long_d = 1'b1;
            state_d    = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        // Excess beats are consumed so the DMA can finish, but never written.
        if (accept) begin
          beat_count_d = beat_count_inc;
          if (keep_bad) begin
            err_keep_d = 1'b1;
          end
          if (s_axis_tlast) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Busy and Done are registered from the next state so they line up
    // with state_q rather than lagging it by a cycle.
    busy_d = (state_d == S_LOAD) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      beat_count_q <= '0;
      fram_data_q  <= '0;
      fram_add_q   <= '0;
      fram_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
      err_keep_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beat_count_q <= beat_count_d;
      fram_data_q  <= fram_data_d;
      fram_add_q   <= fram_add_d;
      fram_en_q    <= fram_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_short_q  <= err_short_d;
      err_long_q   <= err_long_d;
      err_keep_q   <= err_keep_d;
    end
  end

  assign FramData  = fram_data_q;
  assign FramAdd   = fram_add_q;
  assign FramEn    = fram_en_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign ErrShort  = err_short_q;
  assign ErrLong   = err_long_q;
  assign ErrKeep   = err_keep_q;
  assign BeatCount = beat_count_q;

endmodule
